// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO block with input synchroniser, edge-detect
// interrupts and set/clear/toggle output helpers.
//   clk, resetn          : system clock, asynchronous active-low reset
//   sel, we, addr, wdata : bus request (held until ready), direction, byte address, write data
//   rdata, ready         : registered read data and one-cycle acknowledge
//   gpio_i               : raw pad inputs (asynchronous to clk)
//   gpio_o, gpio_oe      : pad output values and output enables (1 = drive)
//   irq                  : level interrupt, OR of all pending bits
module gpio_bank #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sel,
  input  logic              we,
  input  logic [5:0]        addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  input  logic [WIDTH-1:0]  gpio_i,
  output logic [WIDTH-1:0]  gpio_o,
  output logic [WIDTH-1:0]  gpio_oe,
  output logic              irq
);

  localparam int unsigned WARM_W   = 3;
  localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(SYNC_STAGES + 1);

  localparam logic [3:0] A_OUT     = 4'h0;
  localparam logic [3:0] A_OE      = 4'h1;
  localparam logic [3:0] A_IN      = 4'h2;
  localparam logic [3:0] A_OUT_SET = 4'h3;
  localparam logic [3:0] A_OUT_CLR = 4'h4;
  localparam logic [3:0] A_OUT_TGL = 4'h5;
  localparam logic [3:0] A_RISE_EN = 4'h6;
  localparam logic [3:0] A_FALL_EN = 4'h7;
  localparam logic [3:0] A_PEND    = 4'h8;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]  r_prev;
  logic [WIDTH-1:0]  r_out;
  logic [WIDTH-1:0]  r_oe;
  logic [WIDTH-1:0]  r_rise_en;
  logic [WIDTH-1:0]  r_fall_en;
  logic [WIDTH-1:0]  r_pend;
  logic [WARM_W-1:0] r_warm;
  logic              r_ready;
  logic [31:0]       r_rdata;
  logic              r_irq;

  logic              w_ack;
  logic              w_wr;
  logic [3:0]        w_idx;
  logic [WIDTH-1:0]  w_wd;
  logic [WIDTH-1:0]  w_in;
  logic              w_armed;
  logic [WIDTH-1:0]  w_set;
  logic [WIDTH-1:0]  w_clr;
  logic [WIDTH-1:0]  w_pend_next;
  logic [WIDTH-1:0]  w_out_next;
  logic [31:0]       w_rd;
  logic              w_unused;

  // A new access is accepted only when ready is low, so a held sel re-acks every other cycle.
  assign w_ack   = sel & ~r_ready;
  assign w_wr    = w_ack & we;
  assign w_idx   = addr[5:2];
  assign w_wd    = wdata[WIDTH-1:0];
  assign w_in    = r_sync[SYNC_STAGES-1];
  assign w_armed = (r_warm == WARM_MAX);

  // Edges are only trusted once the chain and prev hold post-reset samples.
  assign w_set = w_armed ? (((w_in & ~r_prev) & r_rise_en) | ((~w_in & r_prev) & r_fall_en))
                         : '0;
  assign w_clr = (w_wr && (w_idx == A_PEND)) ? w_wd : '0;
  // Set wins over a simultaneous write-1-to-clear.
  assign w_pend_next = (r_pend & ~w_clr) | w_set;

  // Output register next value, including the set/clear/toggle aliases.
  always_comb begin
    w_out_next = r_out;
    if (w_wr) begin
      case (w_idx)
        A_OUT:     w_out_next = w_wd;
        A_OUT_SET: w_out_next = r_out | w_wd;
        A_OUT_CLR: w_out_next = r_out & ~w_wd;
        A_OUT_TGL: w_out_next = r_out ^ w_wd;
        default:   w_out_next = r_out;
      endcase
    end
  end

  // Read mux; write-only and unmapped locations return zero.
  always_comb begin
    w_rd = '0;
    case (w_idx)
      A_OUT:     w_rd = 32'(r_out);
      A_OE:      w_rd = 32'(r_oe);
      A_IN:      w_rd = 32'(w_in);
      A_RISE_EN: w_rd = 32'(r_rise_en);
      A_FALL_EN: w_rd = 32'(r_fall_en);
      A_PEND:    w_rd = 32'(r_pend);
      default:   w_rd = '0;
    endcase
  end

  // Input synchroniser, previous-value register and warm-up counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= '0;
      r_prev <= '0;
      r_warm <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], gpio_i};
      r_prev <= w_in;
      if (r_warm != WARM_MAX) r_warm <= r_warm + WARM_W'(1);
    end
  end

  // Control registers, pending state and bus response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out     <= '0;
      r_oe      <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_pend    <= '0;
      r_ready   <= 1'b0;
      r_rdata   <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_out   <= w_out_next;
      r_pend  <= w_pend_next;
      r_irq   <= |w_pend_next;
      r_ready <= w_ack;
      r_rdata <= (w_ack && !we) ? w_rd : '0;
      if (w_wr) begin
        if (w_idx == A_OE)      r_oe      <= w_wd;
        if (w_idx == A_RISE_EN) r_rise_en <= w_wd;
        if (w_idx == A_FALL_EN) r_fall_en <= w_wd;
      end
    end
  end

  assign rdata   = r_rdata;
  assign ready   = r_ready;
  assign gpio_o  = r_out;
  assign gpio_oe = r_oe;
  assign irq     = r_irq;

  // Address byte-lane bits and data bits above WIDTH are intentionally ignored.
  assign w_unused = ^{addr[1:0], wdata};

endmodule
